binarization_seq: RTL and testbench

- Sequencer for the binarization engine.
- On a start request it latches the threshold, then issues the int_ctrl pulse (intensity pass).
- It waits for that pass to sweep the full pixel address range, then issues the bin_ctrl pulse (binarize pass) and waits for that sweep as well.
- Reports busy/done/error and drives the two status LEDs; sits between the board control logic (buttons/UART config) and the binarization instance.

---
 rtl/binarization_seq.sv | 151 +++++++++++++++
 tb/tb_binarization_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binarization_seq.sv
// Sequencer for the binarization engine: latches the threshold, fires the
// intensity pass, waits for its address sweep, then does the same for the binarize pass.
module binarization_seq #(
  parameter int ADDR_W     = 16,
  parameter int NUM_PIXELS = 65536,
  parameter int PULSE_LEN  = 10,
  parameter int TIMEOUT    = 70000,
  parameter int CNT_W      = 17
) (
  input  logic              bin_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        thres_cfg,
  input  logic [ADDR_W-1:0] pixel_address,
  output logic [7:0]        thres_length,
  output logic              int_ctrl,
  output logic              bin_ctrl,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        condition_led
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INT_PULSE = 3'd1;
  localparam logic [2:0] S_INT_WAIT  = 3'd2;
  localparam logic [2:0] S_BIN_PULSE = 3'd3;
  localparam logic [2:0] S_BIN_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             armed_nxt;
  logic             idle_like;
  logic             at_last;
  logic             accept_start;
  logic             busy_nxt;
  logic [1:0]       led_nxt;

  // Control handshake: start is a single-cycle request honoured only while
  // idle_like; completion is signalled by a one-cycle done pulse, failure by
  // the error level. There is no back-pressure in either direction.
  assign idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign at_last      = (pixel_address == LAST_ADDR);
  assign accept_start = start && idle_like && !abort;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = CNT_ZERO;
      armed_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept_start) begin
            state_nxt = S_INT_PULSE;
            cnt_nxt   = CNT_ZERO;
          end
        end
        S_INT_PULSE, S_BIN_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state_nxt = (state == S_INT_PULSE) ? S_INT_WAIT : S_BIN_WAIT;
            cnt_nxt   = CNT_ZERO;
            armed_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_INT_WAIT, S_BIN_WAIT: begin
          // A last address left over from the previous sweep must not end
          // the phase; only a fresh arrival after some other address does.
          armed_nxt = armed || !at_last;
          if (armed && at_last) begin
            state_nxt = (state == S_INT_WAIT) ? S_BIN_PULSE : S_DONE;
            cnt_nxt   = CNT_ZERO;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = S_ERROR;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = CNT_ZERO;
          armed_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy_nxt = 1'b0;
    led_nxt  = 2'b00;
    case (state_nxt)
      S_INT_PULSE, S_INT_WAIT: begin
        busy_nxt = 1'b1;
        led_nxt  = 2'b01;
      end
      S_BIN_PULSE, S_BIN_WAIT: begin
        busy_nxt = 1'b1;
        led_nxt  = 2'b10;
      end
      S_DONE:  led_nxt = 2'b11;
      default: led_nxt = 2'b00;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register while still coming straight out of flops.
  always_ff @(posedge bin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= CNT_ZERO;
      armed         <= 1'b0;
      thres_length  <= 8'd40;
      int_ctrl      <= 1'b0;
      bin_ctrl      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      condition_led <= 2'b00;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      armed         <= armed_nxt;
      if (accept_start) thres_length <= thres_cfg;
      int_ctrl      <= (state_nxt == S_INT_PULSE);
      bin_ctrl      <= (state_nxt == S_BIN_PULSE);
      busy          <= busy_nxt;
      done          <= (state == S_BIN_WAIT) && (state_nxt == S_DONE);
      error         <= (state_nxt == S_ERROR);
      condition_led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_binarization_seq.sv
// Randomized scoreboard bench for binarization_seq with a phase-level
// reference model and an emulated engine address sweep.
module tb_binarization_seq;

  localparam int ADDR_W     = 4;
  localparam int NUM_PIXELS = 16;
  localparam int PULSE_LEN  = 4;
  localparam int TIMEOUT    = 40;
  localparam int CNT_W      = 17;
  localparam logic [ADDR_W-1:0] LAST = 4'd15;

  logic              bin_clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [7:0]        thres_cfg;
  logic [ADDR_W-1:0] pixel_address;
  logic [7:0]        thres_length;
  logic              int_ctrl;
  logic              bin_ctrl;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        condition_led;

  always #5 bin_clk = ~bin_clk;

  binarization_seq #(
    .ADDR_W(ADDR_W), .NUM_PIXELS(NUM_PIXELS), .PULSE_LEN(PULSE_LEN),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .bin_clk(bin_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .thres_cfg(thres_cfg), .pixel_address(pixel_address),
    .thres_length(thres_length), .int_ctrl(int_ctrl), .bin_ctrl(bin_ctrl),
    .busy(busy), .done(done), .error(error), .condition_led(condition_led)
  );

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_INT_PULSE, P_INT_WAIT, P_BIN_PULSE, P_BIN_WAIT, P_DONE, P_ERROR} phase_t;
  phase_t            m_ph;
  int                m_pulse_cyc;
  logic [ADDR_W-1:0] m_hist[$];
  logic [7:0]        m_thres;
  logic              m_done_fresh;

  // engine emulation
  int                eng_gap;
  logic              eng_active;
  logic [ADDR_W-1:0] eng_addr;
  logic              freeze;
  logic [ADDR_W-1:0] freeze_val;
  int                gap_cfg;

  logic [14:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_ph = P_IDLE;
    m_pulse_cyc = 0;
    m_hist.delete();
    m_thres = 8'd40;
    m_done_fresh = 1'b0;
    eng_gap = 0;
  endtask

  function automatic logic [14:0] model_out();
    logic [1:0] led;
    logic       bsy;
    bsy = 1'b0;
    led = 2'b00;
    if (m_ph == P_INT_PULSE || m_ph == P_INT_WAIT) begin led = 2'b01; bsy = 1'b1; end
    if (m_ph == P_BIN_PULSE || m_ph == P_BIN_WAIT) begin led = 2'b10; bsy = 1'b1; end
    if (m_ph == P_DONE) led = 2'b11;
    return {m_thres, m_ph == P_INT_PULSE, m_ph == P_BIN_PULSE, bsy, m_done_fresh,
            m_ph == P_ERROR, led};
  endfunction

  // One clock edge of the specified behaviour, phrased per phase: pulses
  // last PULSE_LEN cycles, waits end on a fresh last address or after
  // TIMEOUT cycles of address history.
  task automatic model_advance(input logic s, input logic a, input logic [7:0] cfg,
                               input logic [ADDR_W-1:0] addr);
    int others;
    m_done_fresh = 1'b0;
    if (a) begin
      m_ph = P_IDLE;
      m_hist.delete();
    end else begin
      case (m_ph)
        P_IDLE, P_DONE, P_ERROR: begin
          if (s) begin
            m_thres = cfg;
            m_ph = P_INT_PULSE;
            m_pulse_cyc = 1;
          end
        end
        P_INT_PULSE, P_BIN_PULSE: begin
          if (m_pulse_cyc == PULSE_LEN) begin
            m_ph = (m_ph == P_INT_PULSE) ? P_INT_WAIT : P_BIN_WAIT;
            m_hist.delete();
            eng_gap = gap_cfg;
          end else begin
            m_pulse_cyc++;
          end
        end
        P_INT_WAIT, P_BIN_WAIT: begin
          others = 0;
          foreach (m_hist[i]) if (m_hist[i] != LAST) others++;
          if (addr == LAST && others > 0) begin
            if (m_ph == P_INT_WAIT) begin
              m_ph = P_BIN_PULSE;
              m_pulse_cyc = 1;
            end else begin
              m_ph = P_DONE;
              m_done_fresh = 1'b1;
            end
          end else if (m_hist.size() + 1 == TIMEOUT) begin
            m_ph = P_ERROR;
          end else begin
            m_hist.push_back(addr);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic engine_tick();
    if (eng_gap > 0) begin
      eng_gap--;
      if (eng_gap == 0) begin
        eng_addr = '0;
        eng_active = 1'b1;
      end
    end else if (eng_active && eng_addr != LAST) begin
      eng_addr = eng_addr + 4'd1;
    end
    pixel_address = freeze ? freeze_val : eng_addr;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic a, input logic [7:0] cfg);
    start = s;
    abort = a;
    thres_cfg = cfg;
    engine_tick();
    model_advance(s, a, cfg, pixel_address);
    @(posedge bin_clk);
    #1;
    exp_q.push_back(model_out());
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic run_until(input phase_t target, input int budget, input string name);
    int k;
    k = 0;
    while (m_ph != target && k < budget) begin
      step(1'b0, 1'b0, 8'($urandom));
      k++;
    end
    if (m_ph != target) begin
      n_checks++;
      $display("FAIL %s: phase %0d not reached within %0d cycles", name, target, budget);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [14:0] mon_exp;
  int         int_hi, bin_hi, done_cnt;
  int         int_fall_cyc, bin_rise_cyc, err_rise_cyc;
  logic [ADDR_W-1:0] bin_rise_addr, prev_addr;
  logic       prev_int = 1'b0, prev_bin = 1'b0, prev_err = 1'b0;
  logic [1:0] prev_led = 2'b00;
  logic [1:0] led_seq[$];

  task automatic clear_trackers();
    int_hi = 0; bin_hi = 0; done_cnt = 0;
    int_fall_cyc = -1; bin_rise_cyc = -1; err_rise_cyc = -1;
    bin_rise_addr = '0;
    led_seq.delete();
  endtask

  always @(negedge bin_clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check($sformatf("outputs@%0d", cyc),
            {17'd0, thres_length, int_ctrl, bin_ctrl, busy, done, error, condition_led},
            {17'd0, mon_exp});
    end
    if (int_ctrl) int_hi++;
    if (bin_ctrl) bin_hi++;
    if (done) done_cnt++;
    if (prev_int && !int_ctrl) int_fall_cyc = cyc;
    if (!prev_bin && bin_ctrl) begin
      bin_rise_cyc = cyc;
      bin_rise_addr = prev_addr;
    end
    if (!prev_err && error) err_rise_cyc = cyc;
    if (condition_led != prev_led) led_seq.push_back(condition_led);
    prev_int = int_ctrl;
    prev_bin = bin_ctrl;
    prev_err = error;
    prev_led = condition_led;
    prev_addr = pixel_address;
  end

  // ---------------- stimulus ----------------
  logic [5:0] led_pack;
  logic [7:0] cfg_a;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; thres_cfg = '0; pixel_address = '0;
    eng_active = 1'b0; eng_addr = '0; freeze = 1'b0; freeze_val = '0; gap_cfg = 2;
    model_reset();
    clear_trackers();
    repeat (3) @(posedge bin_clk);
    #2;
    check("reset_thres", {24'd0, thres_length}, 32'd40);
    check("reset_ctrls", {27'd0, int_ctrl, bin_ctrl, busy, done, error}, 32'd0);
    check("reset_led", {30'd0, condition_led}, 32'd0);
    rst_n = 1'b1;

    // idle: random addresses and configs, no start
    freeze = 1'b1;
    repeat (50) begin
      freeze_val = ADDR_W'($urandom_range(0, 15));
      step(1'b0, 1'b0, 8'($urandom));
    end
    freeze = 1'b0;
    check("idle_busy_led", {29'd0, busy, condition_led}, 32'd0);

    // normal run
    clear_trackers();
    gap_cfg = 2;
    step(1'b1, 1'b0, 8'd100);
    run_until(P_DONE, 200, "normal_done");
    idle(3);
    check("normal_thres", {24'd0, thres_length}, 32'd100);
    check("normal_int_len", int_hi, PULSE_LEN);
    check("normal_bin_len", bin_hi, PULSE_LEN);
    check("normal_done_cnt", done_cnt, 1);
    check("normal_bin_after_last", {28'd0, bin_rise_addr}, {28'd0, LAST});
    led_pack = '0;
    foreach (led_seq[i]) led_pack = {led_pack[3:0], led_seq[i]};
    check("normal_led_steps", led_seq.size(), 3);
    check("normal_led_seq", {26'd0, led_pack}, 32'b01_10_11);

    // stale last address at entry to the wait phase
    clear_trackers();
    gap_cfg = 2;
    step(1'b1, 1'b0, 8'($urandom));
    run_until(P_BIN_PULSE, 200, "stale_bin");
    idle(1);
    check("stale_wait_len", bin_rise_cyc - int_fall_cyc, gap_cfg + 15);
    run_until(P_DONE, 200, "stale_done");
    idle(2);
    check("stale_done_cnt", done_cnt, 1);

    // timeout with a frozen address
    clear_trackers();
    freeze = 1'b1;
    freeze_val = 4'd3;
    step(1'b1, 1'b0, 8'($urandom));
    run_until(P_ERROR, 200, "timeout_err");
    idle(1);
    check("timeout_len", err_rise_cyc - int_fall_cyc, TIMEOUT);
    check("timeout_flags", {29'd0, error, busy, done}, 32'b100);
    check("timeout_led", {30'd0, condition_led}, 32'd0);
    freeze = 1'b0;
    step(1'b1, 1'b0, 8'd55);
    idle(1);
    check("restart_clears_error", {30'd0, error, int_ctrl}, 32'b01);
    check("restart_thres", {24'd0, thres_length}, 32'd55);
    run_until(P_DONE, 200, "restart_done");
    idle(2);

    // abort during the second bin pulse cycle
    clear_trackers();
    cfg_a = 8'($urandom_range(1, 254));
    step(1'b1, 1'b0, cfg_a);
    run_until(P_BIN_PULSE, 200, "abort_bin");
    step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    check("abort_outputs", {28'd0, bin_ctrl, busy, condition_led}, 32'd0);
    check("abort_thres", {24'd0, thres_length}, {24'd0, cfg_a});
    step(1'b1, 1'b1, 8'd9);
    check("abort_beats_start", {23'd0, busy, thres_length}, {24'd0, cfg_a});
    idle(10);
    check("abort_no_done", done_cnt, 0);

    // start while busy, then asynchronous reset during the bin wait
    clear_trackers();
    step(1'b1, 1'b0, 8'd77);
    run_until(P_INT_WAIT, 200, "busy_wait");
    step(1'b1, 1'b0, 8'd7);
    idle(1);
    check("busy_start_ignored", {24'd0, thres_length}, 32'd77);
    run_until(P_BIN_WAIT, 200, "reset_binwait");
    idle(3);
    exp_q.delete();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_thres", {24'd0, thres_length}, 32'd40);
    check("async_reset_ctrls", {25'd0, int_ctrl, bin_ctrl, busy, done, error, condition_led}, 32'd0);
    model_reset();
    repeat (2) @(posedge bin_clk);
    #2;
    rst_n = 1'b1;

    // randomized runs with spurious starts, aborts and frozen addresses
    for (int r = 0; r < 10; r++) begin
      gap_cfg = $urandom_range(1, 4);
      freeze = ($urandom_range(0, 4) == 0);
      freeze_val = ADDR_W'($urandom_range(0, 15));
      step(1'b1, 1'b0, 8'($urandom));
      for (int k = 0; k < int'($urandom_range(10, 80)); k++)
        step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
      freeze = 1'b0;
      idle(3);
    end

    @(negedge bin_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
